// File: rtl/minroot_ahb_host.sv
// rtl/minroot_ahb_host.sv - AHB-Lite host that programs, starts and polls the MinRoot VDF CSR slave
module minroot_ahb_host #(
    parameter int          PolyWords        = 4,
    parameter int          IterWords        = 2,
    parameter int          PollGap          = 16,
    parameter logic [31:0] AddrCmdJobId     = 32'h0000_0000,
    parameter logic [31:0] AddrCmdStartIter = 32'h0000_0010,
    parameter logic [31:0] AddrCmdIterCount = 32'h0000_0020,
    parameter logic [31:0] AddrCmdX         = 32'h0000_0040,
    parameter logic [31:0] AddrCmdY         = 32'h0000_0060,
    parameter logic [31:0] AddrCmdStart     = 32'h0000_0080,
    parameter logic [31:0] AddrStatusJobId  = 32'h0000_0100,
    parameter logic [31:0] AddrStatusIter   = 32'h0000_0110,
    parameter logic [31:0] AddrStatusX      = 32'h0000_0140,
    parameter logic [31:0] AddrStatusY      = 32'h0000_0160
) (
    input  logic                      hclk_i,
    input  logic                      hreset_ni,
    input  logic                      job_valid_i,
    output logic                      job_ready_o,
    input  logic [31:0]               job_id_i,
    input  logic [32*IterWords-1:0]   job_start_iter_i,
    input  logic [32*IterWords-1:0]   job_iters_i,
    input  logic [32*PolyWords-1:0]   job_x_i,
    input  logic [32*PolyWords-1:0]   job_y_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [32*IterWords-1:0]   result_iter_o,
    output logic [32*PolyWords-1:0]   result_x_o,
    output logic [32*PolyWords-1:0]   result_y_o,
    output logic                      error_o,
    output logic [31:0]               haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic                      hmastlock_o,
    output logic [31:0]               hwdata_o,
    input  logic [31:0]               hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);
    localparam int IW = 32 * IterWords;
    localparam int PW = 32 * PolyWords;

    localparam logic [7:0]  IterCnt   = 8'(IterWords);
    localparam logic [7:0]  PolyCnt   = 8'(PolyWords);
    localparam logic [7:0]  OffIters  = 8'(IterWords + 1);
    localparam logic [7:0]  OffX      = 8'(2 * IterWords + 1);
    localparam logic [7:0]  OffY      = 8'(2 * IterWords + PolyWords + 1);
    localparam logic [7:0]  WrLast    = 8'(2 * IterWords + 2 * PolyWords + 1);
    localparam logic [7:0]  PollLast  = 8'(IterWords);
    localparam logic [7:0]  FetchLast = 8'(2 * PolyWords - 1);
    localparam logic [15:0] GapLast   = 16'(PollGap > 0 ? PollGap - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_POLL, S_GAP, S_FETCH, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          dphase_q;
    logic [7:0]    idx_q;
    logic [15:0]   gap_q;
    logic          error_q;
    logic [31:0]   job_id_q, snap_id_q;
    logic [IW-1:0] start_q, iters_q, target_q, snap_iter_q, res_iter_q, iter_now;
    logic [PW-1:0] x_q, y_q, res_x_q, res_y_q;

    logic          bus_state, beat_ok, bus_err, last_beat, job_fire, poll_hit;
    logic [7:0]    last_idx, sel;
    logic [31:0]   bus_addr, bus_wdata;
    logic          bus_write;

    function automatic logic [31:0] woff(input logic [7:0] i);
        woff = {22'd0, i, 2'b00};
    endfunction

    function automatic logic [12:0] wbase(input logic [7:0] i);
        wbase = {i, 5'b00000};
    endfunction

    assign bus_state = (state_q == S_WRITE) || (state_q == S_POLL) || (state_q == S_FETCH);
    assign beat_ok   = bus_state && dphase_q && hready_i && !hresp_i;
    assign bus_err   = bus_state && dphase_q && hresp_i;
    assign job_fire  = (state_q == S_IDLE) && job_valid_i;
    assign last_beat = (idx_q == last_idx);

    always_comb begin
        last_idx = FetchLast;
        if (state_q == S_WRITE) last_idx = WrLast;
        else if (state_q == S_POLL) last_idx = PollLast;
    end

    // The last iteration word is still on hrdata_i when the hit is decided.
    always_comb begin
        iter_now = snap_iter_q;
        iter_now[IW-1 -: 32] = hrdata_i;
    end
    assign poll_hit = (snap_id_q == job_id_q) && (iter_now == target_q);

    always_ff @(posedge hclk_i or negedge hreset_ni) begin
        if (!hreset_ni) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (job_fire) state_d = S_WRITE;
            S_WRITE: if (beat_ok && last_beat) state_d = S_POLL;
            S_POLL:  if (beat_ok && last_beat)
                         state_d = poll_hit ? S_FETCH : ((PollGap == 0) ? S_POLL : S_GAP);
            S_GAP:   if (gap_q == GapLast) state_d = S_POLL;
            S_FETCH: if (beat_ok && last_beat) state_d = S_DONE;
            S_DONE:  if (result_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus_err) state_d = S_IDLE;
    end

    always_ff @(posedge hclk_i or negedge hreset_ni) begin
        if (!hreset_ni) begin
            dphase_q    <= 1'b0;
            idx_q       <= '0;
            gap_q       <= '0;
            error_q     <= 1'b0;
            job_id_q    <= '0;
            snap_id_q   <= '0;
            start_q     <= '0;
            iters_q     <= '0;
            target_q    <= '0;
            snap_iter_q <= '0;
            res_iter_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
        end else begin
            // Address phase is always one cycle; the data phase holds until hready or an error.
            dphase_q <= bus_state && (dphase_q ? !(hready_i || hresp_i) : 1'b1);
            if (job_fire || bus_err)  idx_q <= '0;
            else if (beat_ok)         idx_q <= last_beat ? 8'd0 : idx_q + 8'd1;
            gap_q <= (state_q == S_GAP) ? gap_q + 16'd1 : 16'd0;

            if (job_fire) begin
                error_q  <= 1'b0;
                job_id_q <= job_id_i;
                start_q  <= job_start_iter_i;
                iters_q  <= job_iters_i;
                target_q <= job_start_iter_i + job_iters_i;
                x_q      <= job_x_i;
                y_q      <= job_y_i;
            end
            if (bus_err) error_q <= 1'b1;

            if (beat_ok && state_q == S_POLL) begin
                if (idx_q == 8'd0) snap_id_q <= hrdata_i;
                else               snap_iter_q[wbase(idx_q - 8'd1) +: 32] <= hrdata_i;
                if (last_beat && poll_hit) res_iter_q <= iter_now;
            end
            if (beat_ok && state_q == S_FETCH) begin
                if (idx_q < PolyCnt) res_x_q[wbase(idx_q) +: 32] <= hrdata_i;
                else                 res_y_q[wbase(idx_q - PolyCnt) +: 32] <= hrdata_i;
            end
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_write = 1'b0;
        sel       = '0;
        case (state_q)
            S_WRITE: begin
                bus_write = 1'b1;
                if (idx_q == 8'd0) begin
                    bus_addr  = AddrCmdJobId;
                    bus_wdata = job_id_q;
                end else if (idx_q <= IterCnt) begin
                    sel       = idx_q - 8'd1;
                    bus_addr  = AddrCmdStartIter + woff(sel);
                    bus_wdata = start_q[wbase(sel) +: 32];
                end else if (idx_q < OffX) begin
                    sel       = idx_q - OffIters;
                    bus_addr  = AddrCmdIterCount + woff(sel);
                    bus_wdata = iters_q[wbase(sel) +: 32];
                end else if (idx_q < OffY) begin
                    sel       = idx_q - OffX;
                    bus_addr  = AddrCmdX + woff(sel);
                    bus_wdata = x_q[wbase(sel) +: 32];
                end else if (idx_q < WrLast) begin
                    sel       = idx_q - OffY;
                    bus_addr  = AddrCmdY + woff(sel);
                    bus_wdata = y_q[wbase(sel) +: 32];
                end else begin
                    bus_addr  = AddrCmdStart;
                    bus_wdata = 32'd1;
                end
            end
            S_POLL: begin
                sel      = idx_q - 8'd1;
                bus_addr = (idx_q == 8'd0) ? AddrStatusJobId : AddrStatusIter + woff(sel);
            end
            S_FETCH: begin
                sel      = idx_q - PolyCnt;
                bus_addr = (idx_q < PolyCnt) ? AddrStatusX + woff(idx_q) : AddrStatusY + woff(sel);
            end
            default: ;
        endcase
    end

    assign htrans_o       = (bus_state && !dphase_q) ? 2'b10 : 2'b00;
    assign haddr_o        = bus_addr;
    assign hwrite_o       = bus_write;
    assign hwdata_o       = bus_wdata;
    assign hsize_o        = 3'b010;
    assign hburst_o       = 3'b000;
    assign hprot_o        = 4'b0011;
    assign hmastlock_o    = 1'b0;
    assign job_ready_o    = (state_q == S_IDLE);
    assign result_valid_o = (state_q == S_DONE);
    assign result_iter_o  = res_iter_q;
    assign result_x_o     = res_x_q;
    assign result_y_o     = res_y_q;
    assign error_o        = error_q;
endmodule

// File: tb/tb_minroot_ahb_host.sv
// tb/tb_minroot_ahb_host.sv - self-checking bench for minroot_ahb_host with a behavioural CSR slave
module tb_minroot_ahb_host;
    localparam int PW = 4, IW = 2, GAP = 16;
    localparam logic [31:0] A_CJID = 32'h0000, A_CST = 32'h0010, A_CIT = 32'h0020, A_CX = 32'h0040;
    localparam logic [31:0] A_CY = 32'h0060, A_CGO = 32'h0080, A_SJID = 32'h0100, A_SITER = 32'h0110;
    localparam logic [31:0] A_SX = 32'h0140, A_SY = 32'h0160;

    logic hclk_i = 1'b0, hreset_ni = 1'b0;
    logic job_valid_i, job_ready_o, result_valid_o, result_ready_i, error_o;
    logic [31:0] job_id_i;
    logic [32*IW-1:0] job_start_iter_i, job_iters_i, result_iter_o;
    logic [32*PW-1:0] job_x_i, job_y_i, result_x_o, result_y_o;
    logic [31:0] haddr_o, hwdata_o, hrdata_i;
    logic [1:0] htrans_o;
    logic [2:0] hsize_o, hburst_o;
    logic [3:0] hprot_o;
    logic hwrite_o, hmastlock_o, hready_i, hresp_i;

    minroot_ahb_host #(
        .PolyWords(PW), .IterWords(IW), .PollGap(GAP),
        .AddrCmdJobId(A_CJID), .AddrCmdStartIter(A_CST), .AddrCmdIterCount(A_CIT),
        .AddrCmdX(A_CX), .AddrCmdY(A_CY), .AddrCmdStart(A_CGO),
        .AddrStatusJobId(A_SJID), .AddrStatusIter(A_SITER), .AddrStatusX(A_SX), .AddrStatusY(A_SY)
    ) dut (
        .hclk_i(hclk_i), .hreset_ni(hreset_ni),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_id_i(job_id_i),
        .job_start_iter_i(job_start_iter_i), .job_iters_i(job_iters_i),
        .job_x_i(job_x_i), .job_y_i(job_y_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_iter_o(result_iter_o), .result_x_o(result_x_o), .result_y_o(result_y_o),
        .error_o(error_o), .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
        .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
        .hwdata_o(hwdata_o), .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
    );

    always #5 hclk_i = ~hclk_i;

    int cyc = 0;
    always @(posedge hclk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        int          acyc;
        int          dcyc;
    } xfer_t;

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    logic [31:0] tbl_id[$];
    logic [63:0] tbl_iter[$];
    logic [127:0] eng_x, eng_y;
    int  err_at = -1;
    int  wr_count = 0;
    bit  waits_en = 0;
    int  stall_bad = 0;
    int  errors = 0, checks = 0;

    // Behavioural CSR slave: logs every completed transfer, snapshots status on a STATUS_JOB_ID read.
    initial begin : slave
        xfer_t cur;
        bit dp, first;
        int stall, k;
        logic [31:0] snap_id;
        logic [63:0] snap_iter;
        dp = 0; first = 0; stall = 0; k = 0; snap_id = '0; snap_iter = '0;
        cur = '{addr: '0, wr: 1'b0, data: '0, acyc: 0, dcyc: 0};
        hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
        forever begin
            @(negedge hclk_i);
            hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'hdead_beef;
            if (!hreset_ni) begin
                dp = 0;
            end else if (dp) begin
                if (first) begin
                    cur.data = hwdata_o;
                    first = 0;
                end else if (haddr_o !== cur.addr || (cur.wr && hwdata_o !== cur.data)) begin
                    stall_bad++;
                end
                if (htrans_o !== 2'b00) stall_bad++;
                if (stall > 0) begin
                    hready_i = 1'b0;
                    stall--;
                end else begin
                    if (cur.wr) begin
                        if (wr_count == err_at) hresp_i = 1'b1;
                        wr_count++;
                    end else if (cur.addr == A_SJID) begin
                        if (tbl_id.size() > 0) begin
                            snap_id = tbl_id.pop_front();
                            snap_iter = tbl_iter.pop_front();
                        end
                        hrdata_i = snap_id;
                    end else if (cur.addr >= A_SITER && cur.addr < A_SITER + 32'(4*IW)) begin
                        k = int'((cur.addr - A_SITER) >> 2);
                        hrdata_i = snap_iter[32*k +: 32];
                    end else if (cur.addr >= A_SX && cur.addr < A_SX + 32'(4*PW)) begin
                        k = int'((cur.addr - A_SX) >> 2);
                        hrdata_i = eng_x[32*k +: 32];
                    end else if (cur.addr >= A_SY && cur.addr < A_SY + 32'(4*PW)) begin
                        k = int'((cur.addr - A_SY) >> 2);
                        hrdata_i = eng_y[32*k +: 32];
                    end
                    cur.dcyc = cyc;
                    log_q.push_back(cur);
                    dp = 0;
                end
            end
            if (hreset_ni && htrans_o == 2'b10) begin
                cur.addr = haddr_o; cur.wr = hwrite_o; cur.data = '0; cur.acyc = cyc;
                first = 1; dp = 1;
                stall = waits_en ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
        exp_q.push_back('{addr: a, wr: w, data: d, acyc: 0, dcyc: 0});
    endtask

    function automatic int hit_poll(input logic [31:0] id, input logic [63:0] tgt);
        for (int k = 0; k < tbl_id.size(); k++)
            if (tbl_id[k] == id && tbl_iter[k] == tgt) return k + 1;
        return 0;
    endfunction

    // Reference transfer list: program all CMD words, START, then np polls and one fetch.
    task automatic build_exp(input logic [31:0] id, input logic [63:0] st, input logic [63:0] it,
                             input logic [127:0] x, input logic [127:0] y, input int np);
        exp_q.delete();
        push_exp(A_CJID, 1'b1, id);
        for (int i = 0; i < IW; i++) push_exp(A_CST + 32'(4*i), 1'b1, st[32*i +: 32]);
        for (int i = 0; i < IW; i++) push_exp(A_CIT + 32'(4*i), 1'b1, it[32*i +: 32]);
        for (int i = 0; i < PW; i++) push_exp(A_CX + 32'(4*i), 1'b1, x[32*i +: 32]);
        for (int i = 0; i < PW; i++) push_exp(A_CY + 32'(4*i), 1'b1, y[32*i +: 32]);
        push_exp(A_CGO, 1'b1, 32'd1);
        for (int p = 0; p < np; p++) begin
            push_exp(A_SJID, 1'b0, '0);
            for (int i = 0; i < IW; i++) push_exp(A_SITER + 32'(4*i), 1'b0, '0);
        end
        for (int i = 0; i < PW; i++) push_exp(A_SX + 32'(4*i), 1'b0, '0);
        for (int i = 0; i < PW; i++) push_exp(A_SY + 32'(4*i), 1'b0, '0);
    endtask

    task automatic check_log(input string tag, input int n);
        chk({tag, "_xfer_count"}, 128'(log_q.size()), 128'(n));
        for (int i = 0; i < n && i < log_q.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i),
                {log_q[i].addr, log_q[i].wr, log_q[i].wr ? log_q[i].data : 32'd0},
                {exp_q[i].addr, exp_q[i].wr, exp_q[i].data});
    endtask

    task automatic start_job(input string tag, input logic [31:0] id, input logic [63:0] st,
                             input logic [63:0] it, input logic [127:0] x, input logic [127:0] y,
                             output int hs);
        log_q.delete();
        wr_count = 0;
        chk({tag, "_ready_before"}, job_ready_o, 1'b1);
        job_valid_i = 1'b1; job_id_i = id; job_start_iter_i = st; job_iters_i = it;
        job_x_i = x; job_y_i = y;
        @(negedge hclk_i);
        hs = cyc;
        job_valid_i = 1'b0;
        job_id_i = $urandom; job_start_iter_i = {$urandom, $urandom}; job_iters_i = {$urandom, $urandom};
        job_x_i = {$urandom, $urandom, $urandom, $urandom}; job_y_i = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_error_clear"}, error_o, 1'b0);
    endtask

    task automatic run_job(input string tag, input logic [31:0] id, input logic [63:0] st,
                           input logic [63:0] it, input logic [127:0] x, input logic [127:0] y,
                           input bit hold10);
        logic [63:0] tgt;
        logic [127:0] hx, hy, hi;
        int np, hs, n, prev, bad, n0;
        tgt = st + it;
        np = hit_poll(id, tgt);
        eng_x = {$urandom, $urandom, $urandom, $urandom};
        eng_y = {$urandom, $urandom, $urandom, $urandom};
        build_exp(id, st, it, x, y, np);
        stall_bad = 0;
        start_job(tag, id, st, it, x, y, hs);
        n = 0;
        while (!result_valid_o && n < 4000) begin @(negedge hclk_i); n++; end
        chk({tag, "_result_valid"}, result_valid_o, 1'b1);
        check_log(tag, exp_q.size());
        if (log_q.size() > 0) begin
            chk({tag, "_first_addr_cycle"}, 128'(log_q[0].acyc), 128'(hs));
            chk({tag, "_valid_latency"}, 128'(cyc), 128'(log_q[log_q.size()-1].dcyc + 1));
        end
        chk({tag, "_iter"}, result_iter_o, tgt);
        chk({tag, "_x"}, result_x_o, eng_x);
        chk({tag, "_y"}, result_y_o, eng_y);
        chk({tag, "_stall_stable"}, 128'(stall_bad), 128'(0));
        if (!waits_en) begin
            prev = -1;
            foreach (log_q[i]) if (log_q[i].addr == A_SJID && !log_q[i].wr) begin
                if (prev >= 0) chk({tag, "_poll_spacing"}, 128'(log_q[i].acyc - prev), 128'(2*(1+IW) + GAP));
                prev = log_q[i].acyc;
            end
        end
        if (hold10) begin
            hx = result_x_o; hy = result_y_o; hi = 128'(result_iter_o); n0 = log_q.size(); bad = 0;
            repeat (10) begin
                @(negedge hclk_i);
                if (result_x_o !== hx || result_y_o !== hy || 128'(result_iter_o) !== hi ||
                    result_valid_o !== 1'b1 || htrans_o !== 2'b00) bad++;
            end
            chk({tag, "_hold_stable"}, 128'(bad), 128'(0));
            chk({tag, "_hold_no_bus"}, 128'(log_q.size()), 128'(n0));
        end
        result_ready_i = 1'b1;
        @(negedge hclk_i);
        result_ready_i = 1'b0;
        chk({tag, "_back_idle"}, {job_ready_o, result_valid_o}, 2'b10);
    endtask

    initial begin : main
        logic [31:0] id;
        logic [63:0] st, it, tgt;
        int hs, n, nm;
        job_valid_i = 1'b0; result_ready_i = 1'b0; job_id_i = '0;
        job_start_iter_i = '0; job_iters_i = '0; job_x_i = '0; job_y_i = '0;
        eng_x = '0; eng_y = '0;
        repeat (3) @(negedge hclk_i);
        chk("rst_job_ready", job_ready_o, 1'b1);
        chk("rst_valid_err", {result_valid_o, error_o}, 2'b00);
        chk("rst_bus", {htrans_o, haddr_o, hwrite_o, hwdata_o}, '0);
        chk("rst_results", {result_iter_o, result_x_o}, '0);
        chk("fixed_fields", {hsize_o, hburst_o, hprot_o, hmastlock_o}, {3'b010, 3'b000, 4'b0011, 1'b0});
        hreset_ni = 1'b1;
        @(negedge hclk_i);
        chk("post_rst_ready", job_ready_o, 1'b1);

        // Basic job: the engine reaches iteration 100 on the third poll.
        tbl_id = '{32'd5, 32'd5, 32'd5};
        tbl_iter = '{64'd30, 64'd60, 64'd100};
        run_job("basic", 32'd5, 64'd0, 64'd100,
                {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);

        // Iteration target wraps modulo 2^64; status 2^64-1 is a miss.
        id = $urandom;
        tbl_id = '{id, id};
        tbl_iter = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
        run_job("wrap", id, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        // Stale snapshot carrying the previous job id is a miss.
        st = {$urandom, $urandom}; it = {32'd0, $urandom};
        tgt = st + it;
        tbl_id = '{32'd4, 32'd5};
        tbl_iter = '{tgt, tgt};
        run_job("stale", 32'd5, st, it,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        // Random wait states on every transfer.
        waits_en = 1;
        id = $urandom; st = {$urandom, $urandom}; it = {$urandom, $urandom};
        tgt = st + it;
        nm = int'($urandom_range(1, 3));
        tbl_id.delete(); tbl_iter.delete();
        for (int k = 0; k < nm; k++) begin tbl_id.push_back(id); tbl_iter.push_back(tgt - 64'(k + 1)); end
        tbl_id.push_back(id); tbl_iter.push_back(tgt);
        run_job("waits", id, st, it,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        waits_en = 0;

        // Bus error on the CMD_X[1] write aborts the job.
        id = $urandom; st = {$urandom, $urandom}; it = {$urandom, $urandom};
        tbl_id.delete(); tbl_iter.delete();
        build_exp(id, st, it, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 1);
        err_at = 1 + 2*IW + 1;
        start_job("err", id, st, it, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, hs);
        n = 0;
        while (!error_o && n < 200) begin @(negedge hclk_i); n++; end
        chk("err_flag", error_o, 1'b1);
        repeat (30) @(negedge hclk_i);
        check_log("err", err_at + 1);
        chk("err_sticky_ready", {error_o, job_ready_o, htrans_o}, {1'b1, 1'b1, 2'b00});
        err_at = -1;

        // Next job clears the error; result held under backpressure.
        id = $urandom; st = {$urandom, $urandom}; it = {$urandom, $urandom};
        tbl_id = '{id};
        tbl_iter = '{st + it};
        run_job("bp", id, st, it,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // Reset asserted during a poll.
        tbl_id.delete(); tbl_iter.delete();
        for (int k = 0; k < 40; k++) begin tbl_id.push_back(32'd9); tbl_iter.push_back(64'd0); end
        start_job("rst", 32'd7, 64'd1, 64'd1, '1, '1, hs);
        n = 0;
        while (!(htrans_o == 2'b10 && haddr_o == A_SITER) && n < 500) begin @(negedge hclk_i); n++; end
        chk("rst_reach_poll", {htrans_o, haddr_o}, {2'b10, A_SITER});
        hreset_ni = 1'b0;
        #1;
        chk("rst_mid_bus", {htrans_o, haddr_o, hwrite_o, hwdata_o}, '0);
        chk("rst_mid_ctrl", {job_ready_o, result_valid_o, error_o}, 3'b100);
        repeat (2) @(negedge hclk_i);
        hreset_ni = 1'b1;
        tbl_id.delete(); tbl_iter.delete();
        @(negedge hclk_i);
        chk("rst_mid_after", {job_ready_o, htrans_o}, {1'b1, 2'b00});

        id = $urandom; st = {$urandom, $urandom}; it = {$urandom, $urandom};
        tbl_id = '{id};
        tbl_iter = '{st + it};
        run_job("recover", id, st, it,
                {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/minroot_ahb_host.md
# minroot_ahb_host

AHB-Lite master that drives the MinRoot VDF CSR slave from the host side. Accepts a job (job ID, start iteration, iteration count, x, y) on a valid/ready port, programs the CMD_* registers, writes CMD_START, then polls the snapshotting STATUS_* registers until the engine reports the final iteration. It returns the iteration, x and y on a result valid/ready port. It sits between a host-side job source (test sequencer or embedded controller) and the CSR slave bus.

## Interface
- PolyWords, 4, 32-bit words per x/y value.
- IterWords, 2, 32-bit words per iteration value.
- PollGap, 16, idle cycles between a poll miss and the next poll (0 = back-to-back).
- AddrCmdJobId / AddrCmdStartIter / AddrCmdIterCount / AddrCmdX / AddrCmdY / AddrCmdStart, 32-bit, CMD register base byte addresses.
- AddrStatusJobId / AddrStatusIter / AddrStatusX / AddrStatusY, 32-bit, STATUS register base byte addresses.
- hclk_i  in  1  bus clock; the only clock.
- hreset_ni  in  1  asynchronous, active-low reset.
- job_valid_i / job_ready_o  in/out  1  job handshake; transfer when both high.
- job_id_i  in  32  job tag.
- job_start_iter_i, job_iters_i  in  32*IterWords  start iteration, iteration count.
- job_x_i, job_y_i  in  32*PolyWords  starting x, y.
- result_valid_o / result_ready_i  out/in  1  result handshake.
- result_iter_o  out  32*IterWords  final iteration read back.
- result_x_o, result_y_o  out  32*PolyWords  final x, y.
- error_o  out  1  bus error on current/last job.
- haddr_o  out  32; htrans_o  out  2; hwrite_o  out  1; hsize_o  out  3; hburst_o  out  3; hprot_o  out  4; hmastlock_o  out  1; hwdata_o  out  32.
- hrdata_i  in  32; hready_i  in  1; hresp_i  in  1 (0 OKAY, 1 ERROR).

## Operation
- Job fields are latched on acceptance; inputs are ignored after that. target = start_iter + iters, modulo 2^(32*IterWords).
- Multi-word values: word i is at base + 4*i and carries bits [32i+31:32i].
- States:
  - IDLE: job_ready_o=1. On handshake -> WRITE.
  - WRITE: writes in this order: CMD_JOB_ID, CMD_START_ITER[0..IterWords-1], CMD_ITER_COUNT[...], CMD_X[0..PolyWords-1], CMD_Y[...], then CMD_START with data 1. -> POLL.
  - POLL: reads STATUS_JOB_ID first, which triggers the slave snapshot, then STATUS_ITER words. A hit requires job_id match and iter == target; a hit -> FETCH. A miss -> GAP.
  - GAP: counts PollGap cycles -> POLL.
  - FETCH: reads STATUS_X words then STATUS_Y words from the same snapshot. Do not re-read STATUS_JOB_ID. -> DONE.
  - DONE: result_valid_o=1, outputs stable until result_ready_i. Handshake -> IDLE.
- Bus errors:
  - hresp_i=1 in any data phase: abort the job, set error_o, -> IDLE.
  - error_o stays high until the next job handshake clears it.
- Fixed bus fields: hsize_o=3'b010, hburst_o=SINGLE (0), hprot_o=4'b0011, hmastlock_o=0.

## Timing
- Transfers are non-pipelined.
  - Address phase: one cycle with htrans_o=NONSEQ (2'b10), haddr_o/hwrite_o valid.
  - Data phase: next cycle(s), htrans_o=IDLE, hwdata_o held, phase ends on the first cycle with hready_i=1.
  - The next address phase starts the cycle after the data phase ends.
- Each transfer takes 2 cycles with a zero-wait slave. Wait states extend the data phase; hwdata_o and the state are held.
- Read data is sampled on the hready_i=1 cycle of the data phase.
- WRITE is 2+2*IterWords+2*PolyWords transfers (14 at defaults = 28 cycles zero-wait).
- POLL is 1+IterWords transfers. GAP is exactly PollGap cycles. FETCH is 2*PolyWords transfers.
- First WRITE address phase is the cycle after the job handshake. result_valid_o rises the cycle after the last FETCH data phase.
- Reset values:
  - State IDLE, so job_ready_o=1 during and after reset.
  - result_valid_o=0, error_o=0, htrans_o=IDLE, haddr_o=0, hwrite_o=0, hwdata_o=0.
  - result_*_o=0.
- Reset mid-transfer: outputs return to reset values immediately and any pending bus transfer is dropped.

## Test plan
- Zero-wait slave model, job id=5, start=0, iters=100, x=y=incrementing words:
  - Required: 14 writes in the listed order, CMD_START data=1.
  - The model reports iter=100 on the 3rd poll.
  - Result matches the model's x/y; poll spacing = 16 idle cycles.
- Wrap: start=2^64-3, iters=5. The poll hits only at status iter=2. Status iter=2^64-1 is a miss.
- Stale snapshot: status_job_id=4 with iter=target -> treated as a miss. The next poll with id=5 -> hit.
- Wait states: random 0-3 cycle hready_i stalls on every transfer. hwdata_o/haddr_o are stable across each stall and results are unchanged.
- Error: hresp_i=1 on the CMD_X[1] write.
  - Required: no further transfers, error_o=1, job_ready_o=1.
  - The next job handshake clears error_o.
- Backpressure/reset:
  - result_ready_i low for 10 cycles: outputs stable, no bus activity.
  - hreset_ni asserted mid-POLL: outputs at reset values the same cycle.
